// File: rtl/aprx_fpu_pkg.sv
// Shared types and helpers for the approximate FP datapath: operand class
// encoding and the exponent bias of an EXP_W-bit biased exponent field.
package aprx_fpu_pkg;

   typedef enum logic [1:0] {
      FP_ZERO = 2'd0,
      FP_NORM = 2'd1,
      FP_INF  = 2'd2,
      FP_NAN  = 2'd3
   } fp_class_e;

   // Bias of an exp_w-bit exponent field: 2^(exp_w-1)-1
   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/aprx_fp_unpack.sv
// Combinational operand unpack: splits {sign, exp, frac}, classifies the
// operand and builds the truncated significand with its hidden one.
// Denormals are flushed (exp==0 is ZERO whatever the fraction holds).
module aprx_fp_unpack
   import aprx_fpu_pkg::*;
#(
   parameter int EXP_W    = 8,
   parameter int MAN_W    = 7,
   parameter int MAN_KEEP = 7
) (
   input  logic [EXP_W+MAN_W:0] op,
   output logic                 sign,
   output fp_class_e            cls,
   output logic [EXP_W-1:0]     exp,
   output logic [MAN_KEEP:0]    sig
);

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] frac_f;

   assign exp_f  = op[MAN_W +: EXP_W];
   assign frac_f = op[MAN_W-1:0];

   // Classify and keep only the MAN_KEEP fraction MSBs for the multiplier
   always_comb begin
      sign = op[EXP_W+MAN_W];
      exp  = exp_f;
      sig  = {1'b1, frac_f[MAN_W-1 -: MAN_KEEP]};
      cls  = FP_NORM;
      if (exp_f == '0) begin
         cls = FP_ZERO;
      end else if (&exp_f) begin
         cls = (frac_f == '0) ? FP_INF : FP_NAN;
      end
   end

endmodule

// File: rtl/aprx_fp_mul_pipe.sv
// Three-stage elastic approximate floating-point multiplier.
//   S1: unpack/classify both operands
//   S2: significand multiply, biased exponent sum, sign
//   S3: normalise, truncate, special-value resolution, flags
//
// Handshake: a word moves across an interface on any clock edge where
// valid && ready are both high. A producer holds valid and data until that
// edge; res and flags stay stable while out_valid && !out_ready. in_ready is
// derived from downstream occupancy only and never looks at in_valid.
module aprx_fp_mul_pipe
   import aprx_fpu_pkg::*;
#(
   parameter int EXP_W    = 8,
   parameter int MAN_W    = 7,
   parameter int MAN_KEEP = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] op_a,
   input  logic [EXP_W+MAN_W:0] op_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] res,
   output logic                 flag_of,
   output logic                 flag_uf,
   output logic                 flag_nv
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int BIAS = fp_bias(EXP_W);
   localparam int P_W  = 2 * MAN_KEEP + 2;   // full product width
   localparam int HI_W = MAN_KEEP + 2;       // product bits that can reach the result
   localparam int E_W  = EXP_W + 2;          // signed exponent working width

   localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);
   localparam logic [W-1:0] QNAN =
      {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} | (W'(1) << (MAN_W - 1));

   typedef struct packed {
      logic                sign;
      fp_class_e           cls;
      logic [EXP_W-1:0]    exp;
      logic [MAN_KEEP:0]   sig;
   } fp_op_t;

   // ---------------- stage control ----------------
   logic s1_valid, s2_valid, s3_valid;
   logic s1_load, s2_load, s3_load;

   assign s3_load   = !s3_valid || out_ready;
   assign s2_load   = !s2_valid || s3_load;
   assign s1_load   = !s1_valid || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = s3_valid;

   // ---------------- S1: unpack ----------------
   logic                ua_sign, ub_sign;
   fp_class_e           ua_cls, ub_cls;
   logic [EXP_W-1:0]    ua_exp, ub_exp;
   logic [MAN_KEEP:0]   ua_sig, ub_sig;
   fp_op_t              a_u, b_u, s1_a, s1_b;

   aprx_fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .MAN_KEEP(MAN_KEEP)) u_unpack_a (
      .op(op_a), .sign(ua_sign), .cls(ua_cls), .exp(ua_exp), .sig(ua_sig));
   aprx_fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .MAN_KEEP(MAN_KEEP)) u_unpack_b (
      .op(op_b), .sign(ub_sign), .cls(ub_cls), .exp(ub_exp), .sig(ub_sig));

   assign a_u = '{sign: ua_sign, cls: ua_cls, exp: ua_exp, sig: ua_sig};
   assign b_u = '{sign: ub_sign, cls: ub_cls, exp: ub_exp, sig: ub_sig};

   // ---------------- S2: multiply and exponent sum ----------------
   logic                  s2_sign;
   fp_class_e             s2_cls_a, s2_cls_b;
   logic signed [E_W-1:0] s2_exp, exp_sum_d;
   logic [HI_W-1:0]       s2_prod, prod_hi_d;

   // Bits below the kept fraction can never reach the result, so only the
   // top HI_W product bits are registered.
   assign prod_hi_d = HI_W'((P_W'(s1_a.sig) * P_W'(s1_b.sig)) >> MAN_KEEP);
   assign exp_sum_d = $signed({2'b00, s1_a.exp}) + $signed({2'b00, s1_b.exp})
                    - $signed(E_W'(BIAS));

   // ---------------- S3: normalise, pack, flags ----------------
   logic signed [E_W-1:0]   exp_n;
   logic [MAN_KEEP-1:0]     keep_n;
   logic [MAN_KEEP+MAN_W-1:0] frac_fill;
   logic [MAN_W-1:0]        frac_n;
   logic [W-1:0]            res_d;
   logic                    of_d, uf_d, nv_d;

   // Normalise the product, truncate, then resolve specials by priority
   always_comb begin
      exp_n  = s2_exp;
      keep_n = s2_prod[MAN_KEEP-1:0];
      if (s2_prod[HI_W-1]) begin
         exp_n  = s2_exp + E_W'(1);
         keep_n = s2_prod[MAN_KEEP:1];
      end
      frac_fill = {keep_n, {MAN_W{1'b0}}};
      frac_n    = frac_fill[MAN_KEEP+MAN_W-1 -: MAN_W];

      res_d = {s2_sign, exp_n[EXP_W-1:0], frac_n};
      of_d  = 1'b0;
      uf_d  = 1'b0;
      nv_d  = 1'b0;
      if (s2_cls_a == FP_NAN || s2_cls_b == FP_NAN ||
          (s2_cls_a == FP_INF && s2_cls_b == FP_ZERO) ||
          (s2_cls_a == FP_ZERO && s2_cls_b == FP_INF)) begin
         res_d = QNAN;
         nv_d  = 1'b1;
      end else if (s2_cls_a == FP_INF || s2_cls_b == FP_INF) begin
         res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (s2_cls_a == FP_ZERO || s2_cls_b == FP_ZERO) begin
         res_d = {s2_sign, {(W-1){1'b0}}};
      end else if (exp_n >= EXP_MAX) begin
         res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         of_d  = 1'b1;
      end else if (exp_n[E_W-1] || exp_n == '0) begin
         res_d = {s2_sign, {(W-1){1'b0}}};
         uf_d  = 1'b1;
      end
   end

   // Stage valid bits: cleared asynchronously, shift whenever a stage loads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
      end else begin
         if (s1_load) s1_valid <= in_valid;
         if (s2_load) s2_valid <= s1_valid;
         if (s3_load) s3_valid <= s2_valid;
      end
   end

   // S1/S2 data registers: capture only when a valid word moves in
   always_ff @(posedge clk) begin
      if (s1_load && in_valid) begin
         s1_a <= a_u;
         s1_b <= b_u;
      end
      if (s2_load && s1_valid) begin
         s2_sign  <= s1_a.sign ^ s1_b.sign;
         s2_cls_a <= s1_a.cls;
         s2_cls_b <= s1_b.cls;
         s2_exp   <= exp_sum_d;
         s2_prod  <= prod_hi_d;
      end
   end

   // Output register: zero after reset, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res     <= '0;
         flag_of <= 1'b0;
         flag_uf <= 1'b0;
         flag_nv <= 1'b0;
      end else if (s3_load && s2_valid) begin
         res     <= res_d;
         flag_of <= of_d;
         flag_uf <= uf_d;
         flag_nv <= nv_d;
      end
   end

endmodule

// File: tb/tb_aprx_fp_mul_pipe.sv
// Bench for aprx_fp_mul_pipe: default binary16alt build plus a MAN_KEEP=3
// build and a binary8 build, checked against a value-level reference model.
module tb_aprx_fp_mul_pipe;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] op_a, op_b, res;
   logic        flag_of, flag_uf, flag_nv;

   logic        k_in_valid, k_in_ready, k_out_valid, k_out_ready;
   logic [15:0] k_op_a, k_op_b, k_res;
   logic        k_of, k_uf, k_nv;

   logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready;
   logic [7:0]  e_op_a, e_op_b, e_res;
   logic        e_of, e_uf, e_nv;

   aprx_fp_mul_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .flag_of(flag_of), .flag_uf(flag_uf), .flag_nv(flag_nv));

   aprx_fp_mul_pipe #(.EXP_W(8), .MAN_W(7), .MAN_KEEP(3)) dut_k3 (
      .clk(clk), .rst_n(rst_n), .in_valid(k_in_valid), .in_ready(k_in_ready),
      .op_a(k_op_a), .op_b(k_op_b), .out_valid(k_out_valid), .out_ready(k_out_ready),
      .res(k_res), .flag_of(k_of), .flag_uf(k_uf), .flag_nv(k_nv));

   aprx_fp_mul_pipe #(.EXP_W(5), .MAN_W(2), .MAN_KEEP(2)) dut_b8 (
      .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
      .op_a(e_op_a), .op_b(e_op_b), .out_valid(e_out_valid), .out_ready(e_out_ready),
      .res(e_res), .flag_of(e_of), .flag_uf(e_uf), .flag_nv(e_nv));

   // ---------------- scoreboard state ----------------
   int n_pass  = 0;
   int n_total = 0;
   logic [18:0] exp_q[$];   // {nv, uf, of, res[15:0]}

   // Reference model: decode fields, multiply the truncated significands as
   // integers, renormalise by value and apply the special-value priority.
   function automatic logic [18:0] ref_mul(input int a, input int b,
                                           input int ew, input int mw, input int mk);
      int bias, emax, sa, sb, ea, eb, fa, fb, sign, ma, mb, p, one, e, f, r;
      bit za, zb, ia, ib, na, nb;
      bias = (1 << (ew - 1)) - 1;
      emax = (1 << ew) - 1;
      sa = (a >> (ew + mw)) & 1;   sb = (b >> (ew + mw)) & 1;
      ea = (a >> mw) & emax;       eb = (b >> mw) & emax;
      fa = a & ((1 << mw) - 1);    fb = b & ((1 << mw) - 1);
      za = (ea == 0);  zb = (eb == 0);
      ia = (ea == emax) && (fa == 0);  ib = (eb == emax) && (fb == 0);
      na = (ea == emax) && (fa != 0);  nb = (eb == emax) && (fb != 0);
      sign = sa ^ sb;
      if (na || nb || (ia && zb) || (ib && za)) begin
         r = (emax << mw) | (1 << (mw - 1));
         return {1'b1, 1'b0, 1'b0, 16'(r)};
      end
      if (ia || ib) return {3'b000, 16'((sign << (ew + mw)) | (emax << mw))};
      if (za || zb) return {3'b000, 16'(sign << (ew + mw))};
      ma  = (1 << mk) + (fa >> (mw - mk));
      mb  = (1 << mk) + (fb >> (mw - mk));
      p   = ma * mb;               // value = p / 2^(2*mk), in [1, 4)
      one = 1 << (2 * mk);
      e   = ea + eb - bias;
      if (p >= 2 * one) begin
         e = e + 1;
         f = ((p / 2) - one) >> mk;
      end else begin
         f = (p - one) >> mk;
      end
      if (e >= emax) return {3'b001, 16'((sign << (ew + mw)) | (emax << mw))};
      if (e <= 0)    return {3'b010, 16'(sign << (ew + mw))};
      r = (sign << (ew + mw)) | (e << mw) | (f << (mw - mk));
      return {3'b000, 16'(r)};
   endfunction

   // Mostly in-range normal operands, with some fully random encodings
   function automatic logic [15:0] rand_op();
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) v[14:7] = 8'($urandom_range(100, 154));
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic issue_main(input logic [15:0] a, input logic [15:0] b,
                             output int lat, output logic [18:0] got);
      @(negedge clk);
      op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
      got = {flag_nv, flag_uf, flag_of, res};
   endtask

   task automatic issue_k3(input logic [15:0] a, input logic [15:0] b,
                           output int lat, output logic [18:0] got);
      @(negedge clk);
      k_op_a = a; k_op_b = b; k_in_valid = 1'b1;
      @(negedge clk);
      k_in_valid = 1'b0;
      lat = 1;
      while (!k_out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!k_out_valid) lat = -1;
      got = {k_nv, k_uf, k_of, k_res};
   endtask

   task automatic issue_b8(input logic [7:0] a, input logic [7:0] b,
                           output int lat, output logic [18:0] got);
      @(negedge clk);
      e_op_a = a; e_op_b = b; e_in_valid = 1'b1;
      @(negedge clk);
      e_in_valid = 1'b0;
      lat = 1;
      while (!e_out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!e_out_valid) lat = -1;
      got = {e_nv, e_uf, e_of, 8'h00, e_res};
   endtask

   // Stream n random operations through the default DUT. With stress set,
   // out_ready is held low for the first cycles and then toggles randomly,
   // and in_valid has random gaps; otherwise both sides run flat out.
   task automatic run_stream(input int n, input bit stress, input string tag);
      int sent = 0, got_n = 0, cyc = 0, acc_before = 0;
      bit drained = 0, stalled = 0, took = 0;
      logic [18:0] held, e, obs;
      logic [15:0] a, b;
      in_valid = 1'b0;
      while ((sent < n || got_n < n) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         obs = {flag_nv, flag_uf, flag_of, res};
         if (stalled) begin
            n_total++;
            if ({out_valid, obs} !== {1'b1, held})
               $display("FAIL %s_stall_hold: got v=%b %h expected v=1 %h", tag, out_valid, obs, held);
            else n_pass++;
         end
         if (took) begin
            in_valid = 1'b0;
            took = 0;
         end
         out_ready = stress ? (cyc > 6 && $urandom_range(0, 1) == 1) : 1'b1;
         if (!in_valid && sent < n) begin
            if (!stress || cyc <= 6 || $urandom_range(0, 3) != 0) begin
               a = rand_op(); b = rand_op();
               op_a = a; op_b = b; in_valid = 1'b1;
            end
         end
         #1;
         if (!stress && in_valid) begin
            n_total++;
            if (in_ready !== 1'b1)
               $display("FAIL %s_in_ready: got %b expected 1 (cycle %0d)", tag, in_ready, cyc);
            else n_pass++;
         end
         if (out_valid && out_ready) begin
            drained = 1;
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL %s_order: got unexpected result %h expected none", tag, obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) $display("FAIL %s_result: got %h expected %h", tag, obs, e);
               else n_pass++;
            end
            got_n++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_mul(int'(a), int'(b), 8, 7, 7));
            sent++;
            took = 1;
            if (!drained) acc_before++;
         end
         stalled = out_valid && !out_ready;
         held = obs;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_total++;
      if (cyc >= 400 || exp_q.size() != 0)
         $display("FAIL %s_complete: got sent=%0d recv=%0d left=%0d expected %0d/%0d/0",
                  tag, sent, got_n, exp_q.size(), n, n);
      else n_pass++;
      exp_q.delete();
      if (stress) begin
         n_total++;
         if (acc_before != 3)
            $display("FAIL %s_fill_depth: got %0d accepted before first drain expected 3", tag, acc_before);
         else n_pass++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #1;
      n_total++;
      if ({out_valid, res, flag_of, flag_uf, flag_nv} !== 20'h0)
         $display("FAIL reset_outputs: got v=%b res=%h of=%b uf=%b nv=%b expected all 0",
                  out_valid, res, flag_of, flag_uf, flag_nv);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [15:0] ta[3] = '{16'h3FC0, 16'h4000, 16'hBFC0};
      logic [15:0] tb[3] = '{16'h3FC0, 16'h4040, 16'h4000};
      logic [15:0] tr[3] = '{16'h4010, 16'h40C0, 16'hC040};
      int lat;
      logic [18:0] got;
      for (int i = 0; i < 3; i++) begin
         issue_main(ta[i], tb[i], lat, got);
         n_total++;
         if (lat != 3) $display("FAIL basic_latency[%0d]: got %0d expected 3", i, lat);
         else n_pass++;
         n_total++;
         if (got !== {3'b000, tr[i]}) $display("FAIL basic_result[%0d]: got %h expected %h", i, got, {3'b000, tr[i]});
         else n_pass++;
      end
   endtask

   task automatic test_specials();
      logic [15:0] ta[4] = '{16'h7F00, 16'h0080, 16'h7F80, 16'hFF80};
      logic [15:0] tb[4] = '{16'h4000, 16'h3F00, 16'h0000, 16'h4000};
      logic [18:0] tr[4] = '{{3'b001, 16'h7F80}, {3'b010, 16'h0000},
                             {3'b100, 16'h7FC0}, {3'b000, 16'hFF80}};
      int lat;
      logic [18:0] got;
      for (int i = 0; i < 4; i++) begin
         issue_main(ta[i], tb[i], lat, got);
         n_total++;
         if (lat != 3 || got !== tr[i])
            $display("FAIL special[%0d]: got lat=%0d {nv,uf,of,res}=%h expected lat=3 %h", i, lat, got, tr[i]);
         else n_pass++;
      end
   endtask

   task automatic test_approx();
      int lat;
      logic [18:0] got, e;
      logic [15:0] a, b;
      issue_k3(16'h3FFF, 16'h3F80, lat, got);
      n_total++;
      if (lat != 3 || got !== {3'b000, 16'h3FF0})
         $display("FAIL approx_k3: got lat=%0d %h expected lat=3 %h", lat, got, {3'b000, 16'h3FF0});
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         a = rand_op(); b = rand_op();
         e = ref_mul(int'(a), int'(b), 8, 7, 3);
         issue_k3(a, b, lat, got);
         n_total++;
         if (lat != 3 || got !== e)
            $display("FAIL approx_rand[%0d]: %h*%h got lat=%0d %h expected %h", i, a, b, lat, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_binary8();
      logic [7:0] ta[2] = '{8'h3E, 8'h3C};
      logic [7:0] tr[2] = '{8'h40, 8'h3C};
      int lat;
      logic [18:0] got, e;
      logic [7:0] a, b;
      for (int i = 0; i < 2; i++) begin
         issue_b8(ta[i], ta[i], lat, got);
         n_total++;
         if (lat != 3 || got !== {11'h000, tr[i]})
            $display("FAIL b8_directed[%0d]: got lat=%0d %h expected %h", i, lat, got, {11'h000, tr[i]});
         else n_pass++;
      end
      for (int i = 0; i < 6; i++) begin
         a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
         e = ref_mul(int'(a), int'(b), 5, 2, 2);
         issue_b8(a, b, lat, got);
         n_total++;
         if (lat != 3 || got !== e)
            $display("FAIL b8_rand[%0d]: %h*%h got lat=%0d %h expected %h", i, a, b, lat, got, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      run_stream(8, 1'b0, "b2b");
   endtask

   task automatic test_backpressure();
      run_stream(8, 1'b1, "bp");
   endtask

   task automatic test_reset_midop();
      int lat;
      logic [18:0] got;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         op_a = rand_op(); op_b = rand_op(); in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL midrst_full: got v=%b in_ready=%b expected v=1 in_ready=0", out_valid, in_ready);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({out_valid, res, flag_of, flag_uf, flag_nv} !== 20'h0)
         $display("FAIL midrst_async_clear: got v=%b res=%h flags=%b%b%b expected all 0",
                  out_valid, res, flag_of, flag_uf, flag_nv);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
      else n_pass++;
      issue_main(16'h4000, 16'h4040, lat, got);
      n_total++;
      if (lat != 3 || got !== {3'b000, 16'h40C0})
         $display("FAIL midrst_next_op: got lat=%0d %h expected lat=3 %h", lat, got, {3'b000, 16'h40C0});
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL midrst_no_stale: got out_valid=%b expected 0", out_valid);
      else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
      k_in_valid = 1'b0; k_out_ready = 1'b1; k_op_a = '0; k_op_b = '0;
      e_in_valid = 1'b0; e_out_ready = 1'b1; e_op_a = '0; e_op_b = '0;
      test_reset();
      test_basic();
      test_specials();
      test_approx();
      test_binary8();
      test_back_to_back();
      test_backpressure();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global time limit in case a handshake never completes
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion (%0d/%0d so far)", n_pass, n_total);
      $fatal(1, "time limit reached");
   end

endmodule
